fma_write_buffer: RTL
=====================

FMA_WRITE_BUFFER -- requirements
Module: fma_write_buffer

Interface
REQ-001 SHALL have parameter FMA_COUNT, default 2: number of FMAs producing results in lockstep.
REQ-002 SHALL have parameter WORD_WIDTH, default 16: bits per result word.
REQ-003 SHALL have parameter LINE_WIDTH, default 96 (= FMA_COUNT*3*WORD_WIDTH): width of the line handed to memory.
REQ-004 SHALL have port clk_in, input, 1: the single clock.
REQ-005 SHALL have port rst_in, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port fma_c_in, input, FMA_COUNT*WORD_WIDTH: FMA i result at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-007 SHALL have port fma_valid_in, input, 1: all FMA results valid this cycle.
REQ-008 SHALL have port flush_in, input, 1: emit the partially filled line.
REQ-009 SHALL have port read_ack_in, input, 1: memory has latched the line (one-cycle pulse).
REQ-010 SHALL have port write_buffer_read_out, output, LINE_WIDTH: packed line.
REQ-011 SHALL have port write_buffer_valid_out, output, 1: line complete; held high until acked.
REQ-012 SHALL have port ready_out, output, 1: low when a result would be dropped.
REQ-013 SHALL have port overflow_out, output, 1: sticky flag, set when a result was dropped.

Function
REQ-014 Packing SHALL place the result of slot k (0..2), FMA i at bits [k*FMA_COUNT*WORD_WIDTH + i*WORD_WIDTH +: WORD_WIDTH].
REQ-015 States SHALL be FILL (slot count 0..2) and FULL; write_buffer_valid_out SHALL be 1 exactly in FULL.
REQ-016 In FILL, fma_valid_in SHALL write slot[count] and increment count; when the written slot is 2, count SHALL become 0 and the state FULL, so valid is high the cycle after the third result.
REQ-017 In FILL with count>0, flush_in SHALL enter FULL next cycle with unwritten slots zero; a same-cycle result SHALL be written first.
REQ-018 flush_in SHALL be ignored when count==0 (and no same-cycle result) and in FULL.
REQ-019 In FULL, write_buffer_read_out SHALL be stable.
REQ-020 In FULL, a result SHALL be captured into a one-deep pending register if that register is empty.
REQ-021 In FULL with pending occupied and no ack, a result SHALL be dropped and overflow_out set.
REQ-022 ready_out SHALL equal NOT(FULL AND pending occupied).
REQ-023 read_ack_in in FULL SHALL, next cycle:
  - clear all slots to zero;
  - move pending (if any) to slot 0;
  - write a same-cycle result to the next free slot;
  - set count accordingly (0..2);
  - enter FILL.
REQ-024 read_ack_in outside FULL SHALL be ignored.
REQ-025 Arithmetic: none; words SHALL pass bit-exact.

Reset
REQ-026 Reset SHALL have priority over all inputs, including mid-FULL, and SHALL set:
  - state FILL, count 0;
  - all slots and pending cleared;
  - write_buffer_read_out 0, write_buffer_valid_out 0;
  - ready_out 1, overflow_out 0.
REQ-027 overflow_out SHALL clear only on reset.

Structure
REQ-028 FMA_COUNT, WORD_WIDTH, LINE_WIDTH defaults and the FILL/FULL state enum SHALL live in a shared package gpu_pkg, used also by memory.
REQ-029 No sub-module SHALL be instantiated; slot write logic is inline.

Verification (FMA_COUNT=2, WORD_WIDTH=16; fma_c_in is written {fma1,fma0})
REQ-030 Fill case: results {0002,0001}, {0004,0003}, {0006,0005} on consecutive cycles -> valid high the next cycle, line 96'h0006_0005_0004_0003_0002_0001.
REQ-031 Flush case: result {0002,0001}, then flush_in -> valid high, line 96'h0000_0000_0000_0000_0002_0001.
REQ-032 Pending and overflow case: full line, then {0008,0007} -> ready_out 0; then {000A,0009} -> overflow_out 1. Ack -> next line slot0=0007/0008, count 1, ready_out 1.
REQ-033 Ack with same-cycle result: full line with pending {0008,0007}; ack plus result {000C,000B} -> count 2, line bits [63:0]=64'h000C_000B_0008_0007.
REQ-034 Reset case: rst_in asserted while FULL with pending -> next cycle valid 0, line 0, ready 1, overflow 0. A following single result lands in slot 0.
REQ-035 Ignored inputs: read_ack_in in FILL with count 1 and flush_in with count 0 -> no state or output change.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU datapath defaults and the write-buffer line state, also used by the memory side.
package gpu_pkg;

    localparam int unsigned DEFAULT_FMA_COUNT  = 2;
    localparam int unsigned DEFAULT_WORD_WIDTH = 16;
    localparam int unsigned DEFAULT_LINE_WIDTH = DEFAULT_FMA_COUNT * 3 * DEFAULT_WORD_WIDTH;
    localparam int unsigned SLOTS_PER_LINE     = 3;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wb_state_t;

endpackage

// File: rtl/fma_write_buffer.sv
// Packs three lockstep FMA result groups into one memory line, with flush,
// a one-deep pending register while the line awaits ack, and a sticky overflow flag.
module fma_write_buffer
    import gpu_pkg::*;
#(
    parameter int unsigned FMA_COUNT  = DEFAULT_FMA_COUNT,
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int unsigned LINE_WIDTH = DEFAULT_LINE_WIDTH
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_c_in,
    input  logic                            fma_valid_in,
    input  logic                            flush_in,
    input  logic                            read_ack_in,
    output logic [LINE_WIDTH-1:0]           write_buffer_read_out,
    output logic                            write_buffer_valid_out,
    output logic                            ready_out,
    output logic                            overflow_out
);

    localparam int unsigned SLOT_WIDTH = FMA_COUNT * WORD_WIDTH;

    wb_state_t                                   state_q, state_d;
    logic [1:0]                                  count_q, count_d;
    logic [SLOTS_PER_LINE-1:0][SLOT_WIDTH-1:0]   slots_q, slots_d;
    logic [SLOT_WIDTH-1:0]                       pend_q, pend_d;
    logic                                        pend_v_q, pend_v_d;
    logic                                        ovf_q, ovf_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= FILL;
            count_q  <= '0;
            slots_q  <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            slots_q  <= slots_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        slots_d  = slots_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovf_d    = ovf_q;
        case (state_q)
            FILL: begin
                if (fma_valid_in) begin
                    slots_d[count_q] = fma_c_in;
                    if (count_q == 2'd2) begin
                        count_d = '0;
                        state_d = FULL;
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end
                // A same-cycle result counts as written before the flush is judged.
                if (flush_in && state_d == FILL && (count_q != '0 || fma_valid_in)) begin
                    count_d = '0;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (read_ack_in) begin
                    slots_d  = '0;
                    pend_d   = '0;
                    pend_v_d = 1'b0;
                    state_d  = FILL;
                    if (pend_v_q) begin
                        slots_d[0] = pend_q;
                        if (fma_valid_in) begin
                            slots_d[1] = fma_c_in;
                            count_d    = 2'd2;
                        end else begin
                            count_d = 2'd1;
                        end
                    end else if (fma_valid_in) begin
                        slots_d[0] = fma_c_in;
                        count_d    = 2'd1;
                    end else begin
                        count_d = '0;
                    end
                end else if (fma_valid_in) begin
                    if (!pend_v_q) begin
                        pend_d   = fma_c_in;
                        pend_v_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign write_buffer_read_out  = LINE_WIDTH'(slots_q);
    assign write_buffer_valid_out = (state_q == FULL);
    assign ready_out              = !((state_q == FULL) && pend_v_q);
    assign overflow_out           = ovf_q;

endmodule
